transfer_data: RTL and testbench

TRANSFER_DATA -- requirements
Module: transfer_data

---
 rtl/transfer_data_pkg.sv | 30 +++
 rtl/crop_addr_gen.sv | 44 ++++
 rtl/transfer_data.sv | 107 ++++++++++
 tb/tb_transfer_data.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/transfer_data_pkg.sv
// Shared geometry, state encoding and source-address helper for the crop-window copier.
package transfer_data_pkg;

  localparam int SRC_COLS = 256;
  localparam int SRC_ROWS = 128;
  localparam int WIN      = 32;
  localparam int SRC_AW   = 15;
  localparam int DST_AW   = 10;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t READ  = 2'd1;
  localparam state_t FLUSH = 2'd2;
  localparam state_t DONE  = 2'd3;

  // Row and column are added in their own field widths, so each wraps on its own.
  function automatic logic [SRC_AW-1:0] crop_src_addr(
    input logic [DST_AW-1:0] k,
    input logic [6:0]        row0,
    input logic [7:0]        col0
  );
    logic [6:0] row;
    logic [7:0] col;
    row = row0 + {2'b00, k[9:5]};
    col = col0 + {3'b000, k[4:0]};
    return {row, col};
  endfunction

endpackage

// File: rtl/crop_addr_gen.sv
// Pixel counter and registered source-address generator for the 32x32 crop window.
module crop_addr_gen
  import transfer_data_pkg::*;
#(
  parameter int CROP_ROW = 26,
  parameter int CROP_COL = 122
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              adv,
  output logic [DST_AW-1:0] pix,
  output logic [SRC_AW-1:0] addr_src,
  output logic              last
);

  localparam logic [6:0] ROW0 = 7'(CROP_ROW % SRC_ROWS);
  localparam logic [7:0] COL0 = 8'(CROP_COL % SRC_COLS);

  logic [DST_AW-1:0] pix_nxt;

  always_comb begin
    pix_nxt = pix;
    if (load) begin
      pix_nxt = '0;
    end else if (adv) begin
      pix_nxt = pix + DST_AW'(1);
    end
  end

  // pix always names the pixel whose address is currently on addr_src.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix      <= '0;
      addr_src <= '0;
    end else if (load || adv) begin
      pix      <= pix_nxt;
      addr_src <= crop_src_addr(pix_nxt, ROW0, COL0);
    end
  end

  assign last = (pix == DST_AW'(WIN * WIN - 1));

endmodule

// File: rtl/transfer_data.sv
// One-shot 32x32 crop copy: sequencing FSM plus the 1-cycle destination write pipeline.
// Optional simulation checks are compiled in with TRANSFER_DATA_CHECK_EN.
//
// state | meaning
// IDLE  | reset state, starts the read burst on the first clock
// READ  | one source read per cycle, pixels 0..1023
// FLUSH | last destination write, no read
// DONE  | terminal, addresses held, enables low
module transfer_data
  import transfer_data_pkg::*;
#(
  parameter int CROP_ROW = 26,
  parameter int CROP_COL = 122
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ce_src,
  output logic [SRC_AW-1:0] addr_src,
  output logic              ce_dst,
  output logic [DST_AW-1:0] addr_dst
);

  state_t            state, state_nxt;
  logic              gen_load, gen_adv;
  logic              ce_src_nxt, ce_dst_nxt;
  logic [DST_AW-1:0] addr_dst_nxt;
  logic [DST_AW-1:0] pix;
  logic              last;

  crop_addr_gen #(
    .CROP_ROW (CROP_ROW),
    .CROP_COL (CROP_COL)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gen_load),
    .adv      (gen_adv),
    .pix      (pix),
    .addr_src (addr_src),
    .last     (last)
  );

  // The write for the pixel read this cycle lands next cycle, when its data arrives.
  always_comb begin
    state_nxt    = state;
    gen_load     = 1'b0;
    gen_adv      = 1'b0;
    ce_src_nxt   = 1'b0;
    ce_dst_nxt   = 1'b0;
    addr_dst_nxt = addr_dst;
    case (state)
      IDLE: begin
        state_nxt  = READ;
        gen_load   = 1'b1;
        ce_src_nxt = 1'b1;
      end
      READ: begin
        ce_dst_nxt   = 1'b1;
        addr_dst_nxt = pix;
        if (last) begin
          state_nxt = FLUSH;
        end else begin
          gen_adv    = 1'b1;
          ce_src_nxt = 1'b1;
        end
      end
      FLUSH: begin
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ce_src   <= 1'b0;
      ce_dst   <= 1'b0;
      addr_dst <= '0;
    end else begin
      state    <= state_nxt;
      ce_src   <= ce_src_nxt;
      ce_dst   <= ce_dst_nxt;
      addr_dst <= addr_dst_nxt;
    end
  end

`ifdef TRANSFER_DATA_CHECK_EN
  if (CROP_ROW > SRC_ROWS - WIN || CROP_COL > SRC_COLS - WIN) begin : g_fit_chk
    $error("transfer_data: crop window at row %0d col %0d wraps the source image",
           CROP_ROW, CROP_COL);
  end

  // A write must trail a read by one cycle; the FLUSH write trails the last read.
  a_dst_follows_src : assert property (
    @(posedge clk) disable iff (!rst_n) ce_dst |-> ($past(ce_src) || state == FLUSH)
  ) else $error("transfer_data: ce_dst without a preceding ce_src cycle");
`else
  // Wrapping windows are accepted silently; no checking logic.
`endif

endmodule

// File: tb/tb_transfer_data.sv
// Scoreboard bench for transfer_data: default-window DUT plus a wrapping-window DUT.
module tb_transfer_data;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce_src, ce_dst, w_ce_src, w_ce_dst;
  logic [14:0] addr_src, w_addr_src;
  logic [9:0]  addr_dst, w_addr_dst;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = -1;
  int src_cnt = 0;

  logic [14:0] q_src[$];
  logic [9:0]  q_dst[$];
  logic [7:0]  src_mem[32768];
  logic [7:0]  dst_mem[1024];
  logic [7:0]  rd_data;

  always #5 clk = ~clk;

  transfer_data dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce_src   (ce_src),
    .addr_src (addr_src),
    .ce_dst   (ce_dst),
    .addr_dst (addr_dst)
  );

  transfer_data #(.CROP_ROW(120), .CROP_COL(240)) dut_w (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce_src   (w_ce_src),
    .addr_src (w_addr_src),
    .ce_dst   (w_ce_dst),
    .addr_dst (w_addr_dst)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_all();
    int row, col;
    q_src.delete();
    q_dst.delete();
    for (int k = 0; k < 1024; k++) begin
      row = (26 + k / 32) % 128;
      col = (122 + k % 32) % 256;
      q_src.push_back(15'(row * 256 + col));
      q_dst.push_back(10'(k));
    end
  endtask

  // 1-cycle-latency source memory feeding the destination memory directly.
  always @(posedge clk) begin
    if (ce_src) rd_data <= src_mem[addr_src];
    if (ce_dst) dst_mem[addr_dst] <= rd_data;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= -1;
    else        cyc <= cyc + 1;
  end

  // Monitor: pops the scoreboard whenever an enable is presented.
  always @(negedge clk) begin
    logic [14:0] e_src;
    logic [9:0]  e_dst;
    if (rst_n) begin
      if (ce_src) begin
        src_cnt++;
        if (q_src.size() == 0) check("src_queue_empty", 1, 0);
        else begin
          e_src = q_src.pop_front();
          check("addr_src_seq", addr_src, e_src);
        end
      end
      if (ce_dst) begin
        if (q_dst.size() == 0) check("dst_queue_empty", 1, 0);
        else begin
          e_dst = q_dst.pop_front();
          check("addr_dst_seq", addr_dst, e_dst);
        end
      end
      case (cyc)
        0: begin
          check("c0_ce_src", ce_src, 1);
          check("c0_ce_dst", ce_dst, 0);
          check("c0_addr_src", addr_src, 6778);
        end
        1: begin
          check("c1_ce_dst", ce_dst, 1);
          check("c1_addr_dst", addr_dst, 0);
        end
        16: begin
          check("wrap_p16_ce_src", w_ce_src, 1);
          check("wrap_p16_addr_src", w_addr_src, 30720);
        end
        31:   check("c31_addr_src", addr_src, 6809);
        32:   check("c32_addr_src", addr_src, 7034);
        256:  check("wrap_p256_addr_src", w_addr_src, 240);
        1023: check("c1023_addr_src", addr_src, 14745);
        1024: begin
          check("c1024_ce_src", ce_src, 0);
          check("c1024_ce_dst", ce_dst, 1);
          check("c1024_addr_dst", addr_dst, 1023);
          check("wrap_c1024_ce_dst", w_ce_dst, 1);
          check("wrap_c1024_addr_dst", w_addr_dst, 1023);
        end
        1100: begin
          check("done_hold_addr_src", addr_src, 14745);
          check("done_hold_addr_dst", addr_dst, 1023);
        end
        1125: begin
          check("ce_src_cycles", src_cnt, 1024);
          check("src_queue_left", q_src.size(), 0);
          check("dst_queue_left", q_dst.size(), 0);
        end
        default: ;
      endcase
      if (cyc >= 1025 && cyc < 1125)
        check("done_enables", {ce_src, ce_dst, w_ce_src, w_ce_dst}, 0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ce_src"}, ce_src, 0);
    check({tag, "_ce_dst"}, ce_dst, 0);
    check({tag, "_addr_src"}, addr_src, 0);
    check({tag, "_addr_dst"}, addr_dst, 0);
  endtask

  initial begin
    int bad;
    for (int a = 0; a < 32768; a++) src_mem[a] = 8'(a % 256);
    for (int a = 0; a < 1024; a++) dst_mem[a] = 8'h00;

    // Full transfer from reset.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    push_all();
    src_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (1135) @(posedge clk);
    @(negedge clk);

    check("dst0", dst_mem[0], 8'h7A);
    check("dst31", dst_mem[31], 8'h99);
    bad = 0;
    for (int k = 0; k < 1024; k++)
      if (dst_mem[k] !== 8'((122 + k % 32) % 256)) bad++;
    check("dst_all_bad_count", bad, 0);

    // Second run aborted by reset at cycle 500, then run to completion.
    rst_n = 1'b0;
    push_all();
    src_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (501) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    push_all();
    src_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (1135) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
